// File: rtl/keypad_scan16_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer (slave).
interface keypad_scan16_if;
   logic       key_valid;
   logic       key_ready;
   logic [3:0] key_code;

   modport master (output key_valid, output key_code, input key_ready);
   modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scan16.sv
// 4x4 matrix-keypad scanner: column drive, row sync, frame debounce, one event per press,
// plus an 8-key entry shift register.
module keypad_scan16 #(
   parameter int unsigned CLK_DIV = 50000,
   parameter int unsigned DEB_CNT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             row,
   output logic [3:0]             col,
   keypad_scan16_if.master        key,
   output logic                   key_held,
   output logic [31:0]            entry_value,
   output logic                   overrun,
   input  logic                   ovr_clr
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned DebW = ($clog2(DEB_CNT + 1) > 3) ? $clog2(DEB_CNT + 1) : 3;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CNT);

   typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

   logic [3:0]      row_s1, row_s2;
   logic [DivW-1:0] div_cnt;
   logic [1:0]      col_idx, col_nxt;
   logic [15:0]     snap;
   logic            tick, frame_done, eval;

   state_e          state;
   logic [3:0]      cand;
   logic [DebW-1:0] deb_cnt, deb_inc;
   logic            key_valid, press_evt;
   logic [3:0]      key_code;

   logic [4:0]      nbits;
   logic [3:0]      sbit, scode;
   logic            single, is_cand;

   assign tick       = (div_cnt == DivLast);
   assign frame_done = tick && (col_idx == 2'd3);
   assign col_nxt    = col_idx + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1  <= 4'hf;
         row_s2  <= 4'hf;
         div_cnt <= '0;
         col_idx <= '0;
         col     <= 4'b1110;
         snap    <= '0;
         eval    <= 1'b0;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
         eval   <= frame_done;
         if (tick) begin
            div_cnt                    <= '0;
            snap[{col_idx, 2'b00} +: 4] <= ~row_s2;
            col_idx                    <= col_nxt;
            col                        <= ~(4'b0001 << col_nxt);
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // snap bit index is col*4+row; key code is row*4+col, so swap the two halves.
   always_comb begin
      nbits = '0;
      sbit  = '0;
      for (int i = 0; i < 16; i++) begin
         if (snap[i]) begin
            nbits = nbits + 5'd1;
            sbit  = 4'(i);
         end
      end
   end

   assign scode   = {sbit[1:0], sbit[3:2]};
   assign single  = (nbits == 5'd1);
   assign is_cand = single && (scode == cand);
   assign deb_inc = deb_cnt + 1'b1;

   assign press_evt = eval &&
      (((state == StIdle) && single && (DEB_CNT == 1)) ||
       ((state == StDebounce) && is_cand && (deb_inc >= DebLast)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         cand        <= '0;
         deb_cnt     <= '0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         entry_value <= '0;
         overrun     <= 1'b0;
      end else begin
         if (eval) begin
            unique case (state)
               StIdle: begin
                  if (single) begin
                     cand    <= scode;
                     deb_cnt <= DebW'(1);
                     state   <= (DEB_CNT == 1) ? StPressed : StDebounce;
                  end
               end
               StDebounce: begin
                  if (is_cand) begin
                     deb_cnt <= deb_inc;
                     if (deb_inc >= DebLast) state <= StPressed;
                  end else begin
                     state <= StIdle;
                  end
               end
               StPressed: begin
                  if (!is_cand) begin
                     deb_cnt <= DebW'(1);
                     state   <= StRelease;
                  end
               end
               StRelease: begin
                  // A multi-key frame counts toward release, like an empty one.
                  if (is_cand) begin
                     state <= StPressed;
                  end else if (single) begin
                     state <= StIdle;
                  end else begin
                     deb_cnt <= deb_inc;
                     if (deb_inc >= DebLast) state <= StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end

         if (press_evt) begin
            entry_value <= {entry_value[27:0], scode};
            if (!key_valid || key.key_ready) begin
               key_code  <= scode;
               key_valid <= 1'b1;
            end
         end else if (key_valid && key.key_ready) begin
            key_valid <= 1'b0;
         end

         if (press_evt && key_valid && !key.key_ready) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign key.key_valid = key_valid;
   assign key.key_code  = key_code;
   assign key_held      = (state == StPressed) || (state == StRelease);

endmodule

// File: tb/tb_keypad_scan16.sv
// Directed bench for keypad_scan16 with CLK_DIV=4, DEB_CNT=2 (16-cycle frames).
module tb_keypad_scan16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_held;
   logic [31:0] entry_value;
   logic        overrun;
   logic        ovr_clr = 1'b0;
   logic [15:0] keys = '0;
   int          passed = 0;
   int          total = 0;

   keypad_scan16_if kif ();

   keypad_scan16 #(.CLK_DIV(4), .DEB_CNT(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key         (kif),
      .key_held    (key_held),
      .entry_value (entry_value),
      .overrun     (overrun),
      .ovr_clr     (ovr_clr)
   );

   always #5 clk = ~clk;

   // Keypad model: key r*4+c pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hf;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (kif.key_valid) seen = 1'b1;
      end
   endtask

   task automatic pulse_ready();
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;
   endtask

   task automatic test_reset();
      kif.key_ready = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      total++; if (col !== 4'b1110) $display("FAIL reset_col got=%b want=1110", col); else passed++;
      total++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", kif.key_valid); else passed++;
      total++; if (kif.key_code !== 4'h0) $display("FAIL reset_code got=%h want=0", kif.key_code); else passed++;
      total++; if (entry_value !== 32'h0) $display("FAIL reset_entry got=%h want=0", entry_value); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b want=0", overrun); else passed++;
      total++; if (key_held !== 1'b0) $display("FAIL reset_held got=%b want=0", key_held); else passed++;
      cycles(3);
      total++; if (col !== 4'b1110) $display("FAIL col_hold3 got=%b want=1110", col); else passed++;
      cycles(1);
      total++; if (col !== 4'b1101) $display("FAIL col_step got=%b want=1101", col); else passed++;
   endtask

   task automatic test_press();
      bit seen, extra;
      keys = 16'h0040;
      wait_valid(64, seen);
      total++; if (!seen) $display("FAIL press_valid got=0 want=1 within 64 cycles"); else passed++;
      total++; if (kif.key_code !== 4'h6) $display("FAIL press_code got=%h want=6", kif.key_code); else passed++;
      total++; if (entry_value !== 32'h6) $display("FAIL press_entry got=%h want=00000006", entry_value); else passed++;
      cycles(1);
      total++; if (key_held !== 1'b1) $display("FAIL press_held got=%b want=1", key_held); else passed++;
      pulse_ready();
      total++; if (kif.key_valid !== 1'b0) $display("FAIL ack_clear got=%b want=0", kif.key_valid); else passed++;
      extra = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (kif.key_valid) extra = 1'b1;
      end
      total++; if (extra) $display("FAIL no_repeat got=1 want=0"); else passed++;
      keys = '0;
      cycles(64);
      total++; if (key_held !== 1'b0) $display("FAIL release_held got=%b want=0", key_held); else passed++;
   endtask

   task automatic test_bounce();
      bit seen;
      keys = 16'h0040;
      cycles(16);
      keys = '0;
      wait_valid(64, seen);
      total++; if (seen) $display("FAIL bounce_valid got=1 want=0"); else passed++;
      total++; if (entry_value !== 32'h6) $display("FAIL bounce_entry got=%h want=00000006", entry_value); else passed++;
   endtask

   task automatic test_multi();
      bit seen, held;
      keys = 16'h0240;
      seen = 1'b0;
      held = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (kif.key_valid) seen = 1'b1;
         if (key_held) held = 1'b1;
      end
      total++; if (seen) $display("FAIL multi_valid got=1 want=0"); else passed++;
      total++; if (held) $display("FAIL multi_held got=1 want=0"); else passed++;
      keys = '0;
      cycles(48);
   endtask

   task automatic test_overrun();
      bit seen;
      do_reset();
      keys = 16'h0040;
      wait_valid(64, seen);
      total++; if (!seen) $display("FAIL ovr_first_valid got=0 want=1"); else passed++;
      keys = '0;
      cycles(64);
      keys = 16'h0080;
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (entry_value == 32'h67) seen = 1'b1;
      end
      total++; if (entry_value !== 32'h67) $display("FAIL ovr_entry got=%h want=00000067", entry_value); else passed++;
      total++; if (kif.key_code !== 4'h6) $display("FAIL ovr_code got=%h want=6", kif.key_code); else passed++;
      total++; if (kif.key_valid !== 1'b1) $display("FAIL ovr_valid got=%b want=1", kif.key_valid); else passed++;
      cycles(1);
      total++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b want=1", overrun); else passed++;
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      total++; if (overrun !== 1'b0) $display("FAIL ovr_clr got=%b want=0", overrun); else passed++;
      pulse_ready();
      keys = '0;
      cycles(64);
   endtask

   task automatic test_reset_mid();
      bit seen, aligned;
      aligned = 1'b0;
      for (int i = 0; i < 40 && !aligned; i++) begin
         @(negedge clk);
         if (col == 4'b0111) aligned = 1'b1;
      end
      cycles(4);
      total++; if (col !== 4'b1110) $display("FAIL align_col got=%b want=1110", col); else passed++;
      keys = 16'h0040;
      cycles(24);
      total++; if (kif.key_valid !== 1'b0) $display("FAIL mid_pre_valid got=%b want=0", kif.key_valid); else passed++;
      rst = 1'b1;
      cycles(2);
      total++; if (col !== 4'b1110) $display("FAIL rst_mid_col got=%b want=1110", col); else passed++;
      total++; if (entry_value !== 32'h0) $display("FAIL rst_mid_entry got=%h want=0", entry_value); else passed++;
      total++; if (kif.key_code !== 4'h0) $display("FAIL rst_mid_code got=%h want=0", kif.key_code); else passed++;
      total++; if (key_held !== 1'b0) $display("FAIL rst_mid_held got=%b want=0", key_held); else passed++;
      rst = 1'b0;
      wait_valid(64, seen);
      total++; if (!seen) $display("FAIL rst_mid_event got=0 want=1"); else passed++;
      total++; if (kif.key_code !== 4'h6) $display("FAIL rst_mid_evcode got=%h want=6", kif.key_code); else passed++;
      total++; if (entry_value !== 32'h6) $display("FAIL rst_mid_eventry got=%h want=00000006", entry_value); else passed++;
      keys = '0;
   endtask

   initial begin
      kif.key_ready = 1'b0;
      test_reset();
      test_press();
      test_bounce();
      test_multi();
      test_overrun();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
